// File: rtl/order_dispatcher.sv
// Order dispatcher: queues order ids and drives the delivery FSM through its steps.
// Optional ORDER_DISPATCHER_MANUAL_STEP_EN: steps are taken on step_btn rising edges instead of a timer.
module order_dispatcher #(
  parameter int DEPTH       = 4,
  parameter int ID_W        = 4,
  parameter int STEP_CYCLES = 8,
  parameter int RET_TIMEOUT = 16,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             order_req,
  input  logic [ID_W-1:0]  order_id,
  input  logic             step_btn,
  input  logic             y2_in,
  input  logic             y3_in,
  output logic             enable_out,
  output logic             siguiente_out,
  output logic             busy,
  output logic [ID_W-1:0]  cur_id,
  output logic             fifo_full,
  output logic             fifo_empty,
  output logic             overflow,
  output logic             error,
  output logic [CNT_W-1:0] delivered_cnt
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int TMR_MAX = (STEP_CYCLES > RET_TIMEOUT) ? STEP_CYCLES : RET_TIMEOUT;
  localparam int TMR_W   = $clog2(TMR_MAX);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_STEP,
    S_FINAL,
    S_RETURN,
    S_ERROR
  } state_t;

  state_t           state, state_nxt;
  logic [TMR_W-1:0] timer, timer_nxt;
  logic [1:0]       step_cnt, step_cnt_nxt;
  logic             pop, push, step_due;

  logic [ID_W-1:0]  mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count;

  assign fifo_full  = (count == (PTR_W+1)'(DEPTH));
  assign fifo_empty = (count == '0);
  assign cur_id     = fifo_empty ? '0 : mem[rd_ptr];
  // A pop frees a slot in the same cycle, so a request while full is still accepted then.
  assign push       = order_req && (!fifo_full || pop);
  assign busy       = (state != S_IDLE) && (state != S_ERROR);

`ifdef ORDER_DISPATCHER_MANUAL_STEP_EN
  localparam bit TIMED_STEP = 1'b0;
  logic step_btn_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) step_btn_q <= 1'b0;
    else       step_btn_q <= step_btn;
  end

  assign step_due = step_btn && !step_btn_q;
`else
  localparam bit TIMED_STEP = 1'b1;
  logic unused_step_btn;

  assign unused_step_btn = step_btn;
  assign step_due        = (timer == TMR_W'(STEP_CYCLES - 1));
`endif

  // FIFO storage carries data only, so it is left out of reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= order_id;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (order_req && !push) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    timer_nxt    = timer;
    step_cnt_nxt = step_cnt;
    pop          = 1'b0;
    case (state)
      S_IDLE: begin
        if (!fifo_empty && y2_in) state_nxt = S_LAUNCH;
      end
      S_LAUNCH: begin
        step_cnt_nxt = '0;
        timer_nxt    = '0;
        state_nxt    = S_WAIT;
      end
      S_WAIT: begin
        if (step_due) begin
          timer_nxt = '0;
          if (y3_in)                 state_nxt = S_FINAL;
          else if (step_cnt == 2'd3) state_nxt = S_ERROR;
          else                       state_nxt = S_STEP;
        end else if (TIMED_STEP) begin
          timer_nxt = timer + 1'b1;
        end
      end
      S_STEP: begin
        step_cnt_nxt = step_cnt + 2'd1;
        state_nxt    = S_WAIT;
      end
      S_FINAL: begin
        timer_nxt = '0;
        state_nxt = S_RETURN;
      end
      S_RETURN: begin
        if (y2_in) begin
          pop       = 1'b1;
          state_nxt = S_IDLE;
        end else if (timer == TMR_W'(RET_TIMEOUT - 1)) begin
          state_nxt = S_ERROR;
        end else begin
          timer_nxt = timer + 1'b1;
        end
      end
      S_ERROR: state_nxt = S_ERROR;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Pulses are registered from the next state so they line up with the state they belong to.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer         <= '0;
      step_cnt      <= '0;
      enable_out    <= 1'b0;
      siguiente_out <= 1'b0;
      error         <= 1'b0;
      delivered_cnt <= '0;
    end else begin
      timer         <= timer_nxt;
      step_cnt      <= step_cnt_nxt;
      enable_out    <= (state_nxt == S_LAUNCH);
      siguiente_out <= (state_nxt == S_STEP) || (state_nxt == S_FINAL);
      error         <= (state_nxt == S_ERROR);
      if (pop) delivered_cnt <= delivered_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_order_dispatcher.sv
// Bench for order_dispatcher: delivery-FSM model, id scoreboard and timing derived from the stepping rules.
module tb_order_dispatcher;

  localparam int DEPTH       = 4;
  localparam int ID_W        = 4;
  localparam int STEP_CYCLES = 8;
  localparam int RET_TIMEOUT = 16;
  localparam int CNT_W       = 8;
  localparam int GAP         = STEP_CYCLES + 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             order_req;
  logic [ID_W-1:0]  order_id;
  logic             step_btn;
  logic             y2_in;
  logic             y3_in;
  logic             enable_out;
  logic             siguiente_out;
  logic             busy;
  logic [ID_W-1:0]  cur_id;
  logic             fifo_full;
  logic             fifo_empty;
  logic             overflow;
  logic             error;
  logic [CNT_W-1:0] delivered_cnt;

  order_dispatcher #(
    .DEPTH(DEPTH), .ID_W(ID_W), .STEP_CYCLES(STEP_CYCLES),
    .RET_TIMEOUT(RET_TIMEOUT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .order_req(order_req), .order_id(order_id),
    .step_btn(step_btn), .y2_in(y2_in), .y3_in(y3_in),
    .enable_out(enable_out), .siguiente_out(siguiente_out), .busy(busy),
    .cur_id(cur_id), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
    .overflow(overflow), .error(error), .delivered_cnt(delivered_cnt)
  );

  always #5 clk = ~clk;

  // Delivery FSM model: 0 idle, 1 received, 2 prepare, 3 pack/send, 4 delivered, 5 stuck.
  int stage;
  bit stall, early, no_return, hold_low;
  bit both_seen = 1'b0;

  always @(posedge clk or posedge reset) begin
    if (reset)                         stage <= 0;
    else if (enable_out)               stage <= early ? 4 : 1;
    else if (siguiente_out && !stall)  stage <= (stage == 4) ? (no_return ? 5 : 0) : stage + 1;
  end

  assign y2_in = !hold_low && (stage == 0 || stage == 1);
  assign y3_in = (stage == 4);

  always @(negedge clk) begin
    if (enable_out && siguiente_out) both_seen <= 1'b1;
  end

  int               checks = 0;
  int               errors = 0;
  logic [CNT_W-1:0] cnt_exp;
  bit               ovf_exp;
  logic [ID_W-1:0]  q[$];

  task automatic do_reset();
    reset = 1'b1; order_req = 1'b0; order_id = '0; step_btn = 1'b0;
    stall = 0; early = 0; no_return = 0; hold_low = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    cnt_exp = '0; ovf_exp = 0; q.delete();
  endtask

  task automatic push(input logic [ID_W-1:0] id);
    @(negedge clk);
    order_req = 1'b1; order_id = id;
    if (q.size() < DEPTH) q.push_back(id);
    else                  ovf_exp = 1;
    @(negedge clk);
    order_req = 1'b0;
  endtask

  task automatic wait_enable(input string tag, output bit ok);
    int waited = 0;
    ok = 0;
    while (waited < 300 && !ok) begin
      @(negedge clk);
      waited++;
      ok = enable_out;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s.enable_timeout got enable_out=0 after %0d cycles, required a pulse", tag, waited);
    end
  endtask

  // Expects one siguiente pulse GAP cycles later with no pulse in between.
  task automatic expect_pulse(input string tag, input logic [ID_W-1:0] id_exp);
    int quiet_bad = 0;
    repeat (GAP - 1) begin
      @(negedge clk);
      if (enable_out || siguiente_out) quiet_bad++;
    end
    @(negedge clk);
    checks++;
    if (quiet_bad != 0 || siguiente_out !== 1'b1) begin
      errors++;
      $display("FAIL %s.sig_pulse got siguiente=%b stray=%0d, required 1 and 0", tag, siguiente_out, quiet_bad);
    end
    checks++;
    if (cur_id !== id_exp) begin
      errors++;
      $display("FAIL %s.cur_id got %0d required %0d", tag, cur_id, id_exp);
    end
  endtask

  task automatic run_order(input string tag);
    logic [ID_W-1:0] id_exp;
    bit ok;
    checks++;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL %s.scoreboard got empty queue required an order", tag);
      return;
    end
    id_exp = q[0];
    wait_enable(tag, ok);
    if (!ok) return;
    checks++;
    if (cur_id !== id_exp) begin
      errors++;
      $display("FAIL %s.launch_id got %0d required %0d", tag, cur_id, id_exp);
    end
    for (int k = 0; k < 4; k++) expect_pulse(tag, id_exp);
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || delivered_cnt !== cnt_exp) begin
      errors++;
      $display("FAIL %s.return got busy=%b cnt=%0d required 1 and %0d", tag, busy, delivered_cnt, cnt_exp);
    end
    @(negedge clk);
    cnt_exp = cnt_exp + 1'b1;
    void'(q.pop_front());
    checks++;
    if (delivered_cnt !== cnt_exp || busy !== 1'b0 || error !== 1'b0) begin
      errors++;
      $display("FAIL %s.done got cnt=%0d busy=%b error=%b required %0d 0 0",
               tag, delivered_cnt, busy, error, cnt_exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    checks++;
    if (fifo_empty !== 1'b1 || fifo_full !== 1'b0) begin
      errors++;
      $display("FAIL %s.fifo_flags got empty=%b full=%b required 1 0", tag, fifo_empty, fifo_full);
    end
    checks++;
    if (enable_out !== 1'b0 || siguiente_out !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s.ctrl got en=%b sig=%b busy=%b required 0 0 0", tag, enable_out, siguiente_out, busy);
    end
    checks++;
    if (overflow !== 1'b0 || error !== 1'b0) begin
      errors++;
      $display("FAIL %s.sticky got ovf=%b err=%b required 0 0", tag, overflow, error);
    end
    checks++;
    if (delivered_cnt !== '0 || cur_id !== '0) begin
      errors++;
      $display("FAIL %s.values got cnt=%0d cur_id=%0d required 0 0", tag, delivered_cnt, cur_id);
    end
  endtask

  task automatic test_reset();
    do_reset();
    check_reset_values("reset");
  endtask

  task automatic test_single();
    push(4'd5);
    run_order("single");
    checks++;
    if (fifo_empty !== 1'b1) begin
      errors++;
      $display("FAIL single.empty_after got %b required 1", fifo_empty);
    end
  endtask

  task automatic test_overflow();
    hold_low = 1;
    for (int i = 1; i <= 5; i++) push(ID_W'(i));
    repeat (5) @(negedge clk);
    checks++;
    if (fifo_full !== 1'b1 || overflow !== ovf_exp) begin
      errors++;
      $display("FAIL overflow.flags got full=%b ovf=%b required 1 %b", fifo_full, overflow, ovf_exp);
    end
    checks++;
    if (busy !== 1'b0 || error !== 1'b0 || cur_id !== 4'd1) begin
      errors++;
      $display("FAIL overflow.idle_wait got busy=%b err=%b id=%0d required 0 0 1", busy, error, cur_id);
    end
    hold_low = 0;
    while (q.size() > 0) run_order("overflow");
    checks++;
    if (fifo_empty !== 1'b1 || delivered_cnt !== 8'd5) begin
      errors++;
      $display("FAIL overflow.drained got empty=%b cnt=%0d required 1 5", fifo_empty, delivered_cnt);
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      int n;
      do_reset();
      hold_low = 1;
      n = $urandom_range(1, DEPTH + 2);
      for (int i = 0; i < n; i++) push(ID_W'($urandom));
      repeat ($urandom_range(1, 10)) @(negedge clk);
      checks++;
      if (fifo_full !== (q.size() == DEPTH) || overflow !== ovf_exp || cur_id !== q[0]) begin
        errors++;
        $display("FAIL random.queued got full=%b ovf=%b id=%0d required %b %b %0d",
                 fifo_full, overflow, cur_id, q.size() == DEPTH, ovf_exp, q[0]);
      end
      hold_low = 0;
      while (q.size() > 0) run_order("random");
      checks++;
      if (fifo_empty !== 1'b1) begin
        errors++;
        $display("FAIL random.drained got empty=%b required 1", fifo_empty);
      end
    end
  endtask

  task automatic test_early_y3();
    bit ok;
    do_reset();
    early = 1;
    push(4'd9);
    wait_enable("early", ok);
    if (!ok) return;
    expect_pulse("early", 4'd9);
    repeat (2) @(negedge clk);
    checks++;
    if (delivered_cnt !== 8'd1 || busy !== 1'b0 || fifo_empty !== 1'b1) begin
      errors++;
      $display("FAIL early.done got cnt=%0d busy=%b empty=%b required 1 0 1", delivered_cnt, busy, fifo_empty);
    end
  endtask

  task automatic test_stall_error();
    bit ok;
    int stray = 0;
    do_reset();
    stall = 1;
    push(4'd3);
    wait_enable("stall", ok);
    if (!ok) return;
    for (int k = 0; k < 3; k++) expect_pulse("stall", 4'd3);
    repeat (GAP - 1) @(negedge clk);
    checks++;
    if (error !== 1'b0) begin
      errors++;
      $display("FAIL stall.early_error got error=%b required 0", error);
    end
    @(negedge clk);
    checks++;
    if (error !== 1'b1 || siguiente_out !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL stall.error got err=%b sig=%b busy=%b required 1 0 0", error, siguiente_out, busy);
    end
    repeat (20) begin
      @(negedge clk);
      if (enable_out || siguiente_out || !error) stray++;
    end
    checks++;
    if (stray != 0) begin
      errors++;
      $display("FAIL stall.parked got %0d bad cycles required 0", stray);
    end
  endtask

  task automatic test_ret_timeout();
    bit ok;
    int early_err = 0;
    do_reset();
    no_return = 1;
    push(4'd6);
    wait_enable("ret", ok);
    if (!ok) return;
    for (int k = 0; k < 4; k++) expect_pulse("ret", 4'd6);
    repeat (RET_TIMEOUT) begin
      @(negedge clk);
      if (error) early_err++;
    end
    checks++;
    if (early_err != 0) begin
      errors++;
      $display("FAIL ret.early_error got %0d cycles with error required 0", early_err);
    end
    @(negedge clk);
    checks++;
    if (error !== 1'b1 || busy !== 1'b0 || delivered_cnt !== 8'd0) begin
      errors++;
      $display("FAIL ret.timeout got err=%b busy=%b cnt=%0d required 1 0 0", error, busy, delivered_cnt);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    do_reset();
    push(4'd2);
    run_order("midrst");
    hold_low = 1;
    push(4'd11);
    push(4'd12);
    hold_low = 0;
    wait_enable("midrst", ok);
    if (!ok) return;
    repeat (4) @(negedge clk);
    checks++;
    if (busy !== 1'b1 || fifo_empty !== 1'b0 || delivered_cnt !== 8'd1) begin
      errors++;
      $display("FAIL midrst.pre got busy=%b empty=%b cnt=%0d required 1 0 1", busy, fifo_empty, delivered_cnt);
    end
    reset = 1'b1;
    #1;
    check_reset_values("midrst");
    @(negedge clk);
    reset = 1'b0;
    q.delete(); cnt_exp = '0; ovf_exp = 0;
  endtask

`ifdef ORDER_DISPATCHER_MANUAL_STEP_EN
  task automatic test_manual_step();
    bit ok;
    int pulses = 0;
    do_reset();
    push(4'd7);
    wait_enable("manual", ok);
    if (!ok) return;
    repeat (3) @(negedge clk);
    step_btn = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (siguiente_out) pulses++;
    end
    step_btn = 1'b0;
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL manual.held got %0d pulses required 1", pulses);
    end
    for (int p = 0; p < 3; p++) begin
      repeat (3) begin
        @(negedge clk);
        if (siguiente_out) pulses++;
      end
      step_btn = 1'b1;
      repeat (2) begin
        @(negedge clk);
        if (siguiente_out) pulses++;
      end
      step_btn = 1'b0;
    end
    repeat (6) @(negedge clk);
    checks++;
    if (pulses != 4 || delivered_cnt !== 8'd1 || busy !== 1'b0 || error !== 1'b0) begin
      errors++;
      $display("FAIL manual.delivered got pulses=%0d cnt=%0d busy=%b err=%b required 4 1 0 0",
               pulses, delivered_cnt, busy, error);
    end
  endtask
`endif

  task automatic test_exclusive();
    checks++;
    if (both_seen !== 1'b0) begin
      errors++;
      $display("FAIL exclusive.pulses got enable and siguiente together required never");
    end
  endtask

  initial begin
    test_reset();
`ifdef ORDER_DISPATCHER_MANUAL_STEP_EN
    test_manual_step();
`else
    test_single();
    test_overflow();
    test_random();
    test_early_y3();
    test_stall_error();
    test_ret_timeout();
    test_reset_mid();
`endif
    test_exclusive();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got no completion within time limit");
    $fatal(1);
  end

endmodule
